msi_bus_arbiter: RTL

Sequencer and arbiter for the shared snoop bus and single-port backing memory of the two-core MSI cache system. It accepts held requests from the two cache controllers and grants them round-robin. It broadcasts each granted transaction on the common snoop bus with the winner's source id and drives the memory write or read port. For reads, it returns the memory data to the winner; reads are never overlapped.

---
 rtl/msi_bus_pkg.sv | 31 +++
 rtl/rr_pick2.sv | 13 +
 rtl/msi_bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/msi_bus_pkg.sv
// Shared definitions for the two-core MSI cache system: bus commands, line states
// and default bus geometry, used by the arbiter and the cache controllers.
package msi_bus_pkg;

    localparam int ADDR_BITS_DEF     = 11;
    localparam int DATA_BITS_DEF     = 8;
    localparam int MEM_ADDR_BITS_DEF = 6;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'b00,
        BUS_RD     = 2'b01,
        BUS_WR     = 2'b10,
        BUS_UPDATE = 2'b11
    } bus_cmd_e;

    typedef enum logic [1:0] {
        INVALID  = 2'b00,
        SHARED   = 2'b01,
        MODIFIED = 2'b10
    } msi_state_e;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin select: the requester that did not win last time
// takes priority when both are eligible.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       lp,
    output logic       winner,
    output logic       valid
);

    assign valid  = |eligible;
    assign winner = (&eligible) ? ~lp : eligible[1];

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snoop-bus sequencer and memory-port arbiter for two MSI cache controllers.
// Grants round-robin, broadcasts the winner's transaction, and serialises reads.
module msi_bus_arbiter
    import msi_bus_pkg::*;
#(
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF,
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req,
    input  logic [1:0]               cmd0,
    input  logic [1:0]               cmd1,
    input  logic [ADDR_BITS-1:0]     addr0,
    input  logic [ADDR_BITS-1:0]     addr1,
    input  logic [DATA_BITS-1:0]     data0,
    input  logic [DATA_BITS-1:0]     data1,
    output logic [1:0]               gnt,
    output logic [1:0]               bus_cmd,
    output logic [ADDR_BITS-1:0]     bus_addr,
    output logic [DATA_BITS-1:0]     bus_data,
    output logic                     bus_src,
    output logic                     mem_rd_en,
    output logic [MEM_ADDR_BITS-1:0] mem_rd_addr,
    input  logic [DATA_BITS-1:0]     mem_rd_data,
    output logic                     mem_wr_en,
    output logic [MEM_ADDR_BITS-1:0] mem_wr_addr,
    output logic [DATA_BITS-1:0]     mem_wr_data,
    output logic [1:0]               rd_valid,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     busy
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    arb_state_e             state_q;
    logic                   lp_q;
    logic                   rd_src_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [1:0]             gnt_q;
    logic [1:0]             bus_cmd_q;
    logic [ADDR_BITS-1:0]   bus_addr_q;
    logic [DATA_BITS-1:0]   bus_data_q;
    logic                   bus_src_q;
    logic                   mem_rd_en_q;
    logic [MEM_ADDR_BITS-1:0] mem_rd_addr_q;
    logic                   mem_wr_en_q;
    logic [MEM_ADDR_BITS-1:0] mem_wr_addr_q;
    logic [DATA_BITS-1:0]   mem_wr_data_q;
    logic [1:0]             rd_valid_q;
    logic [DATA_BITS-1:0]   rd_data_q;

    logic [1:0]             eligible;
    logic                   pick_winner;
    logic                   pick_valid;
    logic [1:0]             sel_cmd;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [DATA_BITS-1:0]   sel_data;

    // A requester still high during its own grant cycle must not win again.
    assign eligible = req & ~gnt_q;

    rr_pick2 u_pick (
        .eligible (eligible),
        .lp       (lp_q),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    assign sel_cmd  = pick_winner ? cmd1  : cmd0;
    assign sel_addr = pick_winner ? addr1 : addr0;
    assign sel_data = pick_winner ? data1 : data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            lp_q          <= 1'b1;
            rd_src_q      <= 1'b0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            bus_cmd_q     <= '0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_src_q     <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            gnt_q         <= '0;
            bus_cmd_q     <= '0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_src_q     <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            rd_valid_q    <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= onehot2(pick_winner);
                        lp_q       <= pick_winner;
                        bus_cmd_q  <= sel_cmd;
                        bus_addr_q <= sel_addr;
                        bus_data_q <= sel_data;
                        bus_src_q  <= pick_winner;
                        if (sel_cmd == BUS_RD) begin
                            mem_rd_en_q   <= 1'b1;
                            mem_rd_addr_q <= sel_addr[MEM_ADDR_BITS:1];
                            rd_src_q      <= pick_winner;
                            cnt_q         <= CNT_W'(RD_LATENCY - 1);
                            state_q       <= ARB_RD_WAIT;
                        end else if (sel_cmd != BUS_IDLE) begin
                            mem_wr_en_q   <= 1'b1;
                            mem_wr_addr_q <= sel_addr[MEM_ADDR_BITS:1];
                            mem_wr_data_q <= sel_data;
                        end
                    end
                end
                ARB_RD_WAIT: begin
                    // The strobe cycle itself is not counted; countdown starts after it.
                    if (!mem_rd_en_q) begin
                        if (cnt_q == '0) begin
                            rd_data_q  <= mem_rd_data;
                            rd_valid_q <= onehot2(rd_src_q);
                            state_q    <= ARB_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign bus_cmd     = bus_cmd_q;
    assign bus_addr    = bus_addr_q;
    assign bus_data    = bus_data_q;
    assign bus_src     = bus_src_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign busy        = (state_q != ARB_IDLE);

endmodule
